// File: rtl/burst_pkg.sv
// Shared types and sizing for the cache-line burst sequencer.
// BURST_TIMEOUT_EN enables the per-beat idle timeout in cacheline_burst_ctrl.
package burst_pkg;

    localparam int LINE_W          = 256;
    localparam int BEAT_W          = 64;
    localparam int BEATS           = LINE_W / BEAT_W;
    localparam int CNT_W           = $clog2(BEATS);
    localparam int IDLE_CNT_W      = 10;
    localparam int TIMEOUT_DEFAULT = 1023;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } burst_state_t;

endpackage

// File: rtl/line_beat_buffer.sv
// Line assembly register (beat-indexed write, committed on the last beat)
// plus the beat-indexed slice mux used to feed write data to memory.
module line_beat_buffer
    import burst_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  idx,
    input  logic [BEAT_W-1:0] wr_beat,
    input  logic [LINE_W-1:0] src_line,
    output logic [BEAT_W-1:0] rd_beat,
    output logic [LINE_W-1:0] line
);

    // Beats 0..BEATS-2 collect here so the visible line only changes on completion.
    logic [LINE_W-BEAT_W-1:0] partial;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            partial <= '0;
            line    <= '0;
        end else if (wr_en) begin
            if (idx == CNT_W'(BEATS - 1)) begin
                line <= {wr_beat, partial};
            end else begin
                for (int k = 0; k < BEATS - 1; k++) begin
                    if (idx == CNT_W'(k)) partial[k*BEAT_W +: BEAT_W] <= wr_beat;
                end
            end
        end
    end

    always_comb begin
        rd_beat = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (idx == CNT_W'(k)) rd_beat = src_line[k*BEAT_W +: BEAT_W];
        end
    end

endmodule

// File: rtl/cacheline_burst_ctrl.sv
// Converts one line read/write into a 4-beat memory burst and returns a single
// line response. Define BURST_TIMEOUT_EN to abort stalled bursts with line_err.
module cacheline_burst_ctrl
    import burst_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [ADDR_W-1:0] line_address,
    input  logic [LINE_W-1:0] line_wdata,
    output logic [LINE_W-1:0] line_rdata,
    output logic              line_resp,
    output logic              line_err,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [ADDR_W-1:0] bmem_address,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_resp
);

    burst_state_t      state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [BEAT_W-1:0] slice_beat;
    logic              in_burst;
    logic              beat_done;
    logic              last_beat;
    logic              timeout_hit;

    assign in_burst  = (state == READ) || (state == WRITE);
    assign beat_done = in_burst && bmem_resp;
    assign last_beat = beat_done && (cnt == CNT_W'(BEATS - 1));

`ifdef BURST_TIMEOUT_EN
    logic [IDLE_CNT_W-1:0] idle_cnt;
    logic                  err_q;

    // Hitting TIMEOUT-1 with no beat means the count reaches TIMEOUT on this edge.
    assign timeout_hit = in_burst && !bmem_resp && (idle_cnt == IDLE_CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (in_burst && !bmem_resp) idle_cnt <= idle_cnt + 1'b1;
            else                        idle_cnt <= '0;
            if (state_nxt == DONE)      err_q    <= timeout_hit;
        end
    end

    assign line_err = (state == DONE) && err_q;
`else
    assign timeout_hit = 1'b0;
    assign line_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                cnt <= '0;
                if (line_read || line_write) addr_q <= line_address & ~ADDR_W'(31);
            end else if (beat_done) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (line_write)     state_nxt = WRITE;
                else if (line_read) state_nxt = READ;
            end
            READ, WRITE: begin
                if (last_beat || timeout_hit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    line_beat_buffer u_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    ((state == READ) && bmem_resp),
        .idx      (cnt),
        .wr_beat  (bmem_rdata),
        .src_line (line_wdata),
        .rd_beat  (slice_beat),
        .line     (line_rdata)
    );

    assign bmem_read    = (state == READ);
    assign bmem_write   = (state == WRITE);
    assign bmem_address = addr_q;
    assign bmem_wdata   = (state == WRITE) ? slice_beat : '0;
    assign line_resp    = (state == DONE);

endmodule

// File: tb/tb_cacheline_burst_ctrl.sv
// Directed + randomized bench for cacheline_burst_ctrl with a line-level
// reference model (expected line register, beat list, latency rules).
module tb_cacheline_burst_ctrl;
    import burst_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              line_read = 1'b0;
    logic              line_write = 1'b0;
    logic [31:0]       line_address = '0;
    logic [LINE_W-1:0] line_wdata = '0;
    logic [LINE_W-1:0] line_rdata;
    logic              line_resp;
    logic              line_err;
    logic              bmem_read;
    logic              bmem_write;
    logic [31:0]       bmem_address;
    logic [BEAT_W-1:0] bmem_wdata;
    logic [BEAT_W-1:0] bmem_rdata = '0;
    logic              bmem_resp = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [LINE_W-1:0] exp_rdata = '0;

    cacheline_burst_ctrl #(.ADDR_W(32), .TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .line_read    (line_read),
        .line_write   (line_write),
        .line_address (line_address),
        .line_wdata   (line_wdata),
        .line_rdata   (line_rdata),
        .line_resp    (line_resp),
        .line_err     (line_err),
        .bmem_read    (bmem_read),
        .bmem_write   (bmem_write),
        .bmem_address (bmem_address),
        .bmem_wdata   (bmem_wdata),
        .bmem_rdata   (bmem_rdata),
        .bmem_resp    (bmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // mode: 0 = resp every cycle, 1 = every other cycle, 2 = random ~50%
    task automatic line_op(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [LINE_W-1:0] wline, input int mode,
                           input int exp_lat, input bit stray_done);
        logic [BEAT_W-1:0] beats [BEATS];
        bit   is_wr = wr;
        bit   r;
        int   n = 0;
        int   cyc;
        @(negedge clk);
        line_read = rd; line_write = wr; line_address = addr; line_wdata = wline;
        @(negedge clk);
        cyc = 1;
        while (n < BEATS && cyc < 200) begin
            chk("bmem_read", bmem_read, !is_wr);
            chk("bmem_write", bmem_write, is_wr);
            chk("bmem_address", bmem_address, {addr[31:5], 5'b0});
            if (is_wr) chk("bmem_wdata", bmem_wdata, wline[n*BEAT_W +: BEAT_W]);
            chk("line_resp_mid", line_resp, 1'b0);
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = ($urandom_range(1) == 1);
            endcase
            bmem_resp = r;
            bmem_rdata = {$urandom, $urandom};
            if (r) beats[n] = bmem_rdata;
            @(posedge clk);
            if (r) n++;
            @(negedge clk);
            cyc++;
        end
        chk("burst_bound", n, BEATS);
        bmem_resp = 1'b0;
        line_read = 1'b0; line_write = 1'b0;
        if (!is_wr) exp_rdata = {beats[3], beats[2], beats[1], beats[0]};
        chk("line_resp", line_resp, 1'b1);
        chk("line_err", line_err, 1'b0);
        chk("done_no_req", {bmem_read, bmem_write}, 2'b00);
        chk("line_rdata", line_rdata, exp_rdata);
        if (exp_lat > 0) chk("latency", cyc, exp_lat);
        if (stray_done) begin
            bmem_resp = 1'b1;
            bmem_rdata = {$urandom, $urandom};
        end
        @(negedge clk);
        bmem_resp = 1'b0;
        chk("resp_one_cycle", line_resp, 1'b0);
        chk("idle_no_req", {bmem_read, bmem_write}, 2'b00);
        chk("rdata_hold", line_rdata, exp_rdata);
    endtask

    initial begin
        logic [LINE_W-1:0] wl;

        // Reset state
        #1;
        chk("rst_rdata", line_rdata, '0);
        chk("rst_ctrl", {line_resp, line_err, bmem_read, bmem_write}, 4'b0);
        chk("rst_addr", bmem_address, '0);
        chk("rst_wdata", bmem_wdata, '0);
        @(negedge clk); rst = 1'b1;

        // Directed read: beats 11.., 22.., 33.., 44.. returned back to back
        @(negedge clk);
        line_read = 1'b1; line_address = 32'h1000_0024;
        @(negedge clk);
        for (int k = 0; k < BEATS; k++) begin
            chk("rd_addr", bmem_address, 32'h1000_0020);
            chk("rd_req", bmem_read, 1'b1);
            bmem_resp = 1'b1;
            bmem_rdata = {8{8'(8'h11 * (k + 1))}};
            @(negedge clk);
        end
        bmem_resp = 1'b0; line_read = 1'b0;
        exp_rdata = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        chk("rd_resp", line_resp, 1'b1);
        chk("rd_line", line_rdata, exp_rdata);
        @(negedge clk);
        chk("rd_resp_drop", line_resp, 1'b0);

        // Write with beat k = k+1, resp every other cycle
        for (int k = 0; k < BEATS; k++) wl[k*BEAT_W +: BEAT_W] = 64'(k + 1);
        line_op(1'b0, 1'b1, 32'h0000_ABCD, wl, 1, 9, 1'b0);

        // Timing: read with resp every cycle lands line_resp on cycle 5
        line_op(1'b1, 1'b0, 32'h2000_0000, '0, 0, 5, 1'b0);

        // Both requests: write wins
        line_op(1'b1, 1'b1, 32'h3000_0040, rand_line(), 0, 5, 1'b0);

        // Stray resp in DONE and in IDLE
        line_op(1'b1, 1'b0, 32'h4000_0060, '0, 2, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            bmem_resp = 1'b1; bmem_rdata = {$urandom, $urandom};
            @(negedge clk);
            chk("idle_stray_req", {bmem_read, bmem_write, line_resp}, 3'b000);
            chk("idle_stray_rdata", line_rdata, exp_rdata);
        end
        bmem_resp = 1'b0;

        // Reset after 2 read beats
        @(negedge clk);
        line_read = 1'b1; line_address = 32'h5000_0000;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            bmem_resp = 1'b1; bmem_rdata = {$urandom, $urandom};
            @(negedge clk);
        end
        bmem_resp = 1'b0;
        rst = 1'b0;
        #1;
        exp_rdata = '0;
        chk("mid_rst_read", bmem_read, 1'b0);
        chk("mid_rst_resp", line_resp, 1'b0);
        chk("mid_rst_addr", bmem_address, '0);
        chk("mid_rst_rdata", line_rdata, '0);
        line_read = 1'b0;
        @(negedge clk); rst = 1'b1;
        line_op(1'b1, 1'b0, 32'h5000_0000, '0, 0, 5, 1'b0);

        // Randomized line operations
        for (int i = 0; i < 12; i++) begin
            bit w = ($urandom_range(1) == 1);
            line_op(!w, w, $urandom, rand_line(), $urandom_range(2), 0, ($urandom_range(1) == 1));
        end

        // Stalled burst: one beat, then silence
        @(negedge clk);
        line_read = 1'b1; line_address = 32'h6000_0000;
        @(negedge clk);
        bmem_resp = 1'b1; bmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        bmem_resp = 1'b0;
`ifdef BURST_TIMEOUT_EN
        for (int k = 1; k < 9; k++) begin
            chk("to_wait_resp", line_resp, 1'b0);
            chk("to_wait_read", bmem_read, 1'b1);
            @(negedge clk);
        end
        line_read = 1'b0;
        chk("to_resp", line_resp, 1'b1);
        chk("to_err", line_err, 1'b1);
        chk("to_rdata", line_rdata, exp_rdata);
        @(negedge clk);
        chk("to_resp_drop", {line_resp, line_err, bmem_read}, 3'b000);
        line_op(1'b1, 1'b0, 32'h6000_0000, '0, 0, 5, 1'b0);
`else
        for (int k = 1; k < 20; k++) begin
            chk("stall_read", bmem_read, 1'b1);
            chk("stall_resp", {line_resp, line_err}, 2'b00);
            @(negedge clk);
        end
        line_read = 1'b0;
        rst = 1'b0;
        exp_rdata = '0;
        @(negedge clk); rst = 1'b1;
        line_op(1'b1, 1'b0, 32'h6000_0000, '0, 0, 5, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
